morse_tx_engine: RTL and testbench

//  Parametrised Morse transmitter for letters A..H. A Start strobe latches Letter and the pattern
//   is serialised on DotDashOut at SYMBOL_HZ: dot = 1 symbol high, dash = 3 high, 1-symbol gaps.

---
 rtl/morse_pkg.sv | 24 ++
 rtl/morse_rate_tick.sv | 28 ++
 rtl/morse_tx_engine.sv | 149 ++++++++++++++
 tb/tb_morse_tx_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse types and letter tables for A..H.
// Patterns are stored MSB-aligned in a 12-bit field, so the first symbol is always bit 11.
package morse_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} morse_state_t;

  localparam int MORSE_PAT_W = 12;

  localparam logic [MORSE_PAT_W-1:0] MORSE_PAT [8] = '{
    12'b1011_1000_0000,  // A 10111
    12'b1110_1010_1000,  // B 111010101
    12'b1110_1011_1010,  // C 11101011101
    12'b1110_1010_0000,  // D 1110101
    12'b1000_0000_0000,  // E 1
    12'b1010_1110_1000,  // F 101011101
    12'b1110_1110_1000,  // G 111011101
    12'b1010_1010_0000   // H 1010101
  };

  localparam logic [3:0] MORSE_LEN [8] = '{
    4'd5, 4'd9, 4'd11, 4'd7, 4'd1, 4'd9, 4'd9, 4'd7
  };

endpackage

// File: rtl/morse_rate_tick.sv
// Symbol-rate divider: o_tick is high while the count sits at DIV-1.
// i_clr restarts the count so that a newly loaded symbol gets a full period.
module morse_rate_tick #(
  parameter int DIV = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_div;

  assign o_tick = (r_div == CNT_W'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
    end else if (i_clr || o_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/morse_tx_engine.sv
// Morse transmitter for letters A..H with Busy/Done handshake and a one-deep pending buffer.
// Define MORSE_REPEAT_EN for beacon mode: the last letter reloads after every gap, Done never fires.
module morse_tx_engine
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int SYMBOL_HZ       = 2,
  parameter int PATTERN_W       = 12,
  parameter int GAP_BITS        = 3
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [2:0] Letter,
  output logic       DotDashOut,
  output logic       NewBitOut,
  output logic       Busy,
  output logic       Done,
  output logic       Overrun
);

  localparam int TICK_DIV = CLOCK_FREQUENCY / SYMBOL_HZ;
  localparam int BCNT_W   = $clog2(PATTERN_W + 1);
  localparam int GCNT_W   = $clog2(GAP_BITS + 1);

  morse_state_t         r_state;
  logic [PATTERN_W-1:0] r_shift;
  logic [BCNT_W-1:0]    r_bitcnt;
  logic [GCNT_W-1:0]    r_gapcnt;
  logic                 r_pend_vld;
  logic [2:0]           r_pend_letter;

  logic                 w_tick;
  logic                 w_gap_end;
  logic                 w_start_idle;
  logic                 w_have_next;
  logic                 w_load;
  logic [2:0]           w_next_letter;
  logic [2:0]           w_load_letter;
  logic [PATTERN_W-1:0] w_load_shift;

  morse_rate_tick #(
    .DIV(TICK_DIV)
  ) u_rate_tick (
    .i_clk  (ClockIn),
    .i_rst_n(Resetn),
    .i_clr  (w_load),
    .o_tick (w_tick)
  );

  assign w_gap_end    = (r_state == GAP) && w_tick && (r_gapcnt == GCNT_W'(1));
  assign w_start_idle = (r_state == IDLE) && Start;

  // A Start landing on the gap-end cycle with nothing pending is sent directly.
`ifdef MORSE_REPEAT_EN
  logic [2:0] r_letter;

  assign w_have_next   = 1'b1;
  assign w_next_letter = r_pend_vld ? r_pend_letter : (Start ? Letter : r_letter);

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      r_letter <= '0;
    end else if (w_load) begin
      r_letter <= w_load_letter;
    end
  end
`else
  assign w_have_next   = r_pend_vld || Start;
  assign w_next_letter = r_pend_vld ? r_pend_letter : Letter;
`endif

  assign w_load        = w_start_idle || (w_gap_end && w_have_next);
  assign w_load_letter = w_start_idle ? Letter : w_next_letter;

  always_comb begin
    w_load_shift = '0;
    w_load_shift[PATTERN_W-1 -: MORSE_PAT_W] = MORSE_PAT[w_load_letter];
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_gapcnt      <= '0;
      r_pend_vld    <= 1'b0;
      r_pend_letter <= '0;
      DotDashOut    <= 1'b0;
      NewBitOut     <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Overrun       <= 1'b0;
    end else begin
      NewBitOut <= 1'b0;
      Done      <= 1'b0;
      Overrun   <= 1'b0;

      // Pending slot frees up in the same cycle it is consumed at gap end.
      if ((r_state != IDLE) && Start) begin
        if (r_pend_vld && !w_gap_end) begin
          Overrun <= 1'b1;
        end else if (r_pend_vld || !w_gap_end) begin
          r_pend_vld    <= 1'b1;
          r_pend_letter <= Letter;
        end
      end else if (w_gap_end) begin
        r_pend_vld <= 1'b0;
      end

      if (w_load) begin
        r_state    <= SEND;
        r_shift    <= w_load_shift;
        r_bitcnt   <= BCNT_W'(MORSE_LEN[w_load_letter]);
        r_gapcnt   <= '0;
        DotDashOut <= w_load_shift[PATTERN_W-1];
        NewBitOut  <= 1'b1;
        Busy       <= 1'b1;
      end else if (w_tick) begin
        unique case (r_state)
          SEND: begin
            NewBitOut <= 1'b1;
            r_shift   <= r_shift << 1;
            r_bitcnt  <= r_bitcnt - 1'b1;
            if (r_bitcnt == BCNT_W'(1)) begin
              r_state    <= GAP;
              r_gapcnt   <= GCNT_W'(GAP_BITS);
              DotDashOut <= 1'b0;
            end else begin
              DotDashOut <= r_shift[PATTERN_W-2];
            end
          end
          GAP: begin
            r_gapcnt <= r_gapcnt - 1'b1;
            if (r_gapcnt == GCNT_W'(1)) begin
              r_state <= IDLE;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end else begin
              NewBitOut <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_tx_engine.sv
// Self-checking bench for morse_tx_engine (4 cycles/symbol, 3-symbol gap).
// Build with MORSE_REPEAT_EN defined on both RTL and bench to exercise beacon mode.
module tb_morse_tx_engine;

  localparam int P        = 4;
  localparam int GAP_BITS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       Start = 1'b0;
  logic [2:0] Letter = 3'd0;
  logic       DotDashOut, NewBitOut, Busy, Done, Overrun;

  int n_vec = 0;
  int n_bad = 0;

  morse_tx_engine #(
    .CLOCK_FREQUENCY(8),
    .SYMBOL_HZ      (2),
    .PATTERN_W      (12),
    .GAP_BITS       (GAP_BITS)
  ) dut (
    .ClockIn   (clk),
    .Resetn    (rst_n),
    .Start     (Start),
    .Letter    (Letter),
    .DotDashOut(DotDashOut),
    .NewBitOut (NewBitOut),
    .Busy      (Busy),
    .Done      (Done),
    .Overrun   (Overrun)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: each letter expands to a list of symbols, each held P cycles.
  bit  m_q[$];
  int  m_cyc, m_pend, m_last;
  bit  m_busy, m_pend_vld, m_done, m_ovr, m_nb, m_dot;

  function automatic string morse_code(input int l);
    case (l)
      0: return ".-";
      1: return "-...";
      2: return "-.-.";
      3: return "-..";
      4: return ".";
      5: return "..-.";
      6: return "--.";
      default: return "....";
    endcase
  endfunction

  function automatic void begin_letter(input int l);
    string s;
    s = morse_code(l);
    m_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (i != 0) m_q.push_back(1'b0);
      if (s[i] == "-") begin
        m_q.push_back(1'b1); m_q.push_back(1'b1); m_q.push_back(1'b1);
      end else begin
        m_q.push_back(1'b1);
      end
    end
    for (int g = 0; g < GAP_BITS; g++) m_q.push_back(1'b0);
    m_cyc  = 0;
    m_nb   = 1'b1;
    m_busy = 1'b1;
    m_last = l;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_cyc = 0; m_pend = 0; m_last = 0;
    m_busy = 0; m_pend_vld = 0; m_done = 0; m_ovr = 0; m_nb = 0; m_dot = 0;
  endfunction

  function automatic void model_step(input bit st, input int l);
    bit was_busy, ended;
    was_busy = m_busy;
    ended = 1'b0;
    m_done = 0; m_ovr = 0; m_nb = 0;
    if (m_busy) begin
      m_cyc++;
      if (m_cyc == P) begin
        m_cyc = 0;
        void'(m_q.pop_front());
        if (m_q.size() != 0) m_nb = 1'b1;
        else ended = 1'b1;
      end
    end
    if (!was_busy) begin
      if (st) begin_letter(l);
    end else if (ended) begin
      if (m_pend_vld) begin
        begin_letter(m_pend);
        m_pend_vld = 0;
        if (st) begin m_pend = l; m_pend_vld = 1; end
      end else if (st) begin
        begin_letter(l);
      end else begin
`ifdef MORSE_REPEAT_EN
        begin_letter(m_last);
`else
        m_busy = 0;
        m_done = 1;
`endif
      end
    end else if (st) begin
      if (m_pend_vld) m_ovr = 1;
      else begin m_pend = l; m_pend_vld = 1; end
    end
    m_dot = m_busy ? m_q[0] : 1'b0;
  endfunction

  logic [4:0] exp_out;
  int cnt_busy = 0, cnt_done = 0, cnt_ovr = 0, cnt_ones = 0, cnt_nb = 0;

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(Start, int'(Letter));
    exp_out = {m_dot, m_nb, m_busy, m_done, m_ovr};
    #1;
    check("outputs{dot,nb,busy,done,ovr}", {DotDashOut, NewBitOut, Busy, Done, Overrun}, exp_out);
    if (rst_n) begin
      cnt_busy += int'(Busy);
      cnt_done += int'(Done);
      cnt_ovr  += int'(Overrun);
      cnt_ones += int'(DotDashOut);
      cnt_nb   += int'(NewBitOut);
    end
  end

  int b_busy, b_done, b_ovr, b_ones, b_nb;

  task automatic snap();
    b_busy = cnt_busy; b_done = cnt_done; b_ovr = cnt_ovr; b_ones = cnt_ones; b_nb = cnt_nb;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [2:0] l);
    @(negedge clk);
    Start  = 1'b1;
    Letter = l;
    @(negedge clk);
    Start  = 1'b0;
    Letter = 3'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (Busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", Busy, 1'b0);
  endtask

  typedef struct {
    logic [2:0] letter;
    int         busy;
    int         nb;
    int         ones;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{3'd0, 32,  8, 16};
    tbl[1] = '{3'd1, 48, 12, 24};
    tbl[2] = '{3'd2, 56, 14, 32};
    tbl[3] = '{3'd3, 40, 10, 20};
    tbl[4] = '{3'd4, 16,  4,  4};
    tbl[5] = '{3'd5, 48, 12, 24};
    tbl[6] = '{3'd6, 48, 12, 28};
    tbl[7] = '{3'd7, 40, 10, 16};

    #1 rst_n = 1'b0;
    idle_cycles(3);
    check("reset_outputs", {DotDashOut, NewBitOut, Busy, Done, Overrun}, 5'b0);
    rst_n = 1'b1;
    idle_cycles(2);

`ifndef MORSE_REPEAT_EN
    for (int i = 0; i < 8; i++) begin
      snap();
      pulse_start(tbl[i].letter);
      wait_idle(100);
      idle_cycles(1);
      check("tbl_busy_cycles", cnt_busy - b_busy, tbl[i].busy);
      check("tbl_newbit_count", cnt_nb - b_nb, tbl[i].nb);
      check("tbl_on_cycles", cnt_ones - b_ones, tbl[i].ones);
      check("tbl_done_count", cnt_done - b_done, 1);
    end

    snap();
    pulse_start(3'd0);
    idle_cycles(5);
    pulse_start(3'd3);
    wait_idle(200);
    idle_cycles(1);
    check("AD_busy_cycles", cnt_busy - b_busy, 72);
    check("AD_on_cycles", cnt_ones - b_ones, 36);
    check("AD_done_count", cnt_done - b_done, 1);

    snap();
    pulse_start(3'd0);
    idle_cycles(2);
    pulse_start(3'd2);
    idle_cycles(2);
    pulse_start(3'd5);
    wait_idle(300);
    idle_cycles(1);
    check("ACF_overrun_count", cnt_ovr - b_ovr, 1);
    check("ACF_on_cycles", cnt_ones - b_ones, 48);
    check("ACF_done_count", cnt_done - b_done, 1);

    pulse_start(3'd2);
    idle_cycles(3);
    check("C_dash_before_reset", {DotDashOut, Busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("reset_abort_outputs", {DotDashOut, NewBitOut, Busy, Done, Overrun}, 5'b0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    snap();
    pulse_start(3'd7);
    wait_idle(100);
    idle_cycles(1);
    check("H_after_reset_on_cycles", cnt_ones - b_ones, 16);
    check("H_after_reset_done", cnt_done - b_done, 1);
`else
    snap();
    pulse_start(3'd1);
    idle_cycles(200);
    check("repeat_no_done", cnt_done - b_done, 0);
    check("repeat_still_busy", Busy, 1'b1);
    pulse_start(3'd4);
    idle_cycles(120);
    check("repeat_replace_no_done", cnt_done - b_done, 0);
`endif

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      Start  = ($urandom_range(0, 15) == 0);
      Letter = 3'($urandom);
    end
    @(negedge clk);
    Start = 1'b0;
`ifndef MORSE_REPEAT_EN
    wait_idle(400);
`endif
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
